// File: rtl/lcd_bus_driver.sv
// rtl/lcd_bus_driver.sv - 8080-style parallel LCD bus engine: write/read strobe sequencing with dummy-read discard
module lcd_bus_driver #(
    parameter int WR_LOW    = 2,
    parameter int WR_HIGH   = 2,
    parameter int RD_ID_LOW = 4,
    parameter int RD_FM_LOW = 10,
    parameter int RD_HIGH   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        we,
    input  logic        wr,
    input  logic        lcd_rs_i,
    input  logic [15:0] data,
    input  logic        id_fm,
    input  logic        read_color,
    output logic        busy,
    output logic        write_ok,
    output logic        write_color_ok,
    output logic        rd_valid,
    output logic [15:0] rd_data,
    output logic        rd_done,
    output logic        lcd_cs_n,
    output logic        lcd_wr_n,
    output logic        lcd_rd_n,
    output logic        lcd_rs,
    output logic [15:0] lcd_data_o,
    output logic        lcd_data_oe,
    input  logic [15:0] lcd_data_i
);

    localparam int MAX_W = (WR_LOW > WR_HIGH) ? WR_LOW : WR_HIGH;
    localparam int MAX_R = (RD_ID_LOW > RD_FM_LOW) ? RD_ID_LOW : RD_FM_LOW;
    localparam int MAX_WR = (MAX_W > MAX_R) ? MAX_W : MAX_R;
    localparam int MAX_P = (MAX_WR > RD_HIGH) ? MAX_WR : RD_HIGH;
    localparam int CW = $clog2(MAX_P + 1);

    localparam logic [CW-1:0] WR_LO_END = CW'(WR_LOW - 1);
    localparam logic [CW-1:0] WR_HI_END = CW'(WR_HIGH - 1);
    localparam logic [CW-1:0] RD_ID_END = CW'(RD_ID_LOW - 1);
    localparam logic [CW-1:0] RD_FM_END = CW'(RD_FM_LOW - 1);
    localparam logic [CW-1:0] RD_HI_END = CW'(RD_HIGH - 1);

    typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [1:0]    strobe, strobe_n;
    logic          rs_q, rs_n, id_fm_q, id_fm_n, color_q, color_n;
    logic [15:0]   data_q, data_n;
    logic [CW-1:0] rd_lo_end;
    logic [1:0]    last_strobe;
    logic          write_ok_n, write_color_ok_n, rd_valid_n, rd_done_n;
    logic [15:0]   rd_data_n;
    logic          oe_n;

    always_comb begin
        state_n          = state;
        cnt_n            = cnt + 1'b1;
        strobe_n         = strobe;
        rs_n             = rs_q;
        data_n           = data_q;
        id_fm_n          = id_fm_q;
        color_n          = color_q;
        write_ok_n       = 1'b0;
        write_color_ok_n = 1'b0;
        rd_valid_n       = 1'b0;
        rd_done_n        = 1'b0;
        rd_data_n        = rd_data;
        rd_lo_end        = id_fm_q ? RD_FM_END : RD_ID_END;
        last_strobe      = color_q ? 2'd2 : 2'd1;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (we) begin
                    state_n  = wr ? WR_LO : RD_LO;
                    rs_n     = lcd_rs_i;
                    data_n   = data;
                    id_fm_n  = id_fm;
                    color_n  = read_color;
                    strobe_n = 2'd0;
                end
            end
            WR_LO: begin
                if (cnt == WR_LO_END) begin
                    state_n = WR_HI;
                    cnt_n   = '0;
                end
            end
            WR_HI: begin
                if (cnt == WR_HI_END) begin
                    state_n          = IDLE;
                    cnt_n            = '0;
                    write_ok_n       = 1'b1;
                    write_color_ok_n = rs_q;
                end
            end
            RD_LO: begin
                if (cnt == rd_lo_end) begin
                    state_n = RD_HI;
                    cnt_n   = '0;
                    // strobe 0 is the controller's dummy read and is dropped
                    if (strobe != 2'd0) begin
                        rd_data_n  = lcd_data_i;
                        rd_valid_n = 1'b1;
                    end
                end
            end
            RD_HI: begin
                if (cnt == RD_HI_END) begin
                    cnt_n = '0;
                    if (strobe == last_strobe) begin
                        state_n   = IDLE;
                        rd_done_n = 1'b1;
                    end else begin
                        state_n  = RD_LO;
                        strobe_n = strobe + 2'd1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        oe_n = (state_n == WR_LO) || (state_n == WR_HI);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            cnt            <= '0;
            strobe         <= 2'd0;
            rs_q           <= 1'b1;
            data_q         <= 16'h0;
            id_fm_q        <= 1'b0;
            color_q        <= 1'b0;
            busy           <= 1'b0;
            write_ok       <= 1'b0;
            write_color_ok <= 1'b0;
            rd_valid       <= 1'b0;
            rd_data        <= 16'h0;
            rd_done        <= 1'b0;
            lcd_cs_n       <= 1'b1;
            lcd_wr_n       <= 1'b1;
            lcd_rd_n       <= 1'b1;
            lcd_rs         <= 1'b1;
            lcd_data_o     <= 16'h0;
            lcd_data_oe    <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            strobe         <= strobe_n;
            rs_q           <= rs_n;
            data_q         <= data_n;
            id_fm_q        <= id_fm_n;
            color_q        <= color_n;
            busy           <= (state_n != IDLE);
            write_ok       <= write_ok_n;
            write_color_ok <= write_color_ok_n;
            rd_valid       <= rd_valid_n;
            rd_data        <= rd_data_n;
            rd_done        <= rd_done_n;
            lcd_cs_n       <= (state_n == IDLE);
            lcd_wr_n       <= (state_n != WR_LO);
            lcd_rd_n       <= (state_n != RD_LO);
            lcd_rs         <= (state_n == IDLE) ? 1'b1 : rs_n;
            lcd_data_o     <= oe_n ? data_n : 16'h0;
            lcd_data_oe    <= oe_n;
        end
    end

endmodule

// File: tb/tb_lcd_bus_driver.sv
// tb/tb_lcd_bus_driver.sv - self-checking bench for lcd_bus_driver with a cycle-schedule reference model
module tb_lcd_bus_driver;

    localparam int WR_LOW = 2, WR_HIGH = 2, RD_ID_LOW = 4, RD_FM_LOW = 10, RD_HIGH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        we = 1'b0, wr = 1'b0, lcd_rs_i = 1'b0, id_fm = 1'b0, read_color = 1'b0;
    logic [15:0] data = 16'h0;
    logic [15:0] lcd_data_i = 16'h0;
    logic        busy, write_ok, write_color_ok, rd_valid, rd_done;
    logic [15:0] rd_data, lcd_data_o;
    logic        lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs, lcd_data_oe;

    int checks = 0;
    int errors = 0;

    lcd_bus_driver #(
        .WR_LOW(WR_LOW), .WR_HIGH(WR_HIGH), .RD_ID_LOW(RD_ID_LOW),
        .RD_FM_LOW(RD_FM_LOW), .RD_HIGH(RD_HIGH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .wr(wr), .lcd_rs_i(lcd_rs_i),
        .data(data), .id_fm(id_fm), .read_color(read_color),
        .busy(busy), .write_ok(write_ok), .write_color_ok(write_color_ok),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_done(rd_done),
        .lcd_cs_n(lcd_cs_n), .lcd_wr_n(lcd_wr_n), .lcd_rd_n(lcd_rd_n), .lcd_rs(lcd_rs),
        .lcd_data_o(lcd_data_o), .lcd_data_oe(lcd_data_oe), .lcd_data_i(lcd_data_i)
    );

    always #5 clk = ~clk;

    // expected pin state for one clock cycle
    typedef struct packed {
        logic        busy, cs_n, wr_n, rd_n, rs, oe;
        logic [15:0] dout;
        logic        wok, wcok, rdv, rdd, smp;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    logic [15:0] m_rd;

    function automatic exp_t idle_e();
        exp_t e;
        e = '0;
        e.cs_n = 1'b1; e.wr_n = 1'b1; e.rd_n = 1'b1; e.rs = 1'b1;
        return e;
    endfunction

    task automatic gen_write(input logic rs, input logic [15:0] d);
        exp_t e;
        for (int i = 0; i < WR_LOW + WR_HIGH; i++) begin
            e = idle_e();
            e.busy = 1'b1; e.cs_n = 1'b0; e.wr_n = (i >= WR_LOW); e.rs = rs; e.oe = 1'b1; e.dout = d;
            q.push_back(e);
        end
        e = idle_e(); e.wok = 1'b1; e.wcok = rs;
        q.push_back(e);
    endtask

    task automatic gen_read(input logic rs, input logic idf, input logic rc);
        exp_t e;
        int n, lo;
        n  = rc ? 3 : 2;
        lo = idf ? RD_FM_LOW : RD_ID_LOW;
        for (int s = 0; s < n; s++) begin
            for (int i = 0; i < lo + RD_HIGH; i++) begin
                e = idle_e();
                e.busy = 1'b1; e.cs_n = 1'b0; e.rs = rs;
                e.rd_n = (i >= lo);
                e.smp  = (s > 0) && (i == lo - 1);
                e.rdv  = (s > 0) && (i == lo);
                q.push_back(e);
            end
        end
        e = idle_e(); e.rdd = 1'b1;
        q.push_back(e);
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            cur  = idle_e();
            m_rd = 16'h0;
        end else begin
            if (cur.smp) m_rd = lcd_data_i;
            if (!cur.busy && q.size() == 0 && we) begin
                if (wr) gen_write(lcd_rs_i, data);
                else    gen_read(lcd_rs_i, id_fm, read_color);
            end
            cur = (q.size() != 0) ? q.pop_front() : idle_e();
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("busy", {15'h0, busy}, {15'h0, cur.busy});
        chk("cs_n", {15'h0, lcd_cs_n}, {15'h0, cur.cs_n});
        chk("wr_n", {15'h0, lcd_wr_n}, {15'h0, cur.wr_n});
        chk("rd_n", {15'h0, lcd_rd_n}, {15'h0, cur.rd_n});
        chk("rs", {15'h0, lcd_rs}, {15'h0, cur.rs});
        chk("oe", {15'h0, lcd_data_oe}, {15'h0, cur.oe});
        chk("data_o", lcd_data_o, cur.dout);
        chk("write_ok", {15'h0, write_ok}, {15'h0, cur.wok});
        chk("write_color_ok", {15'h0, write_color_ok}, {15'h0, cur.wcok});
        chk("rd_valid", {15'h0, rd_valid}, {15'h0, cur.rdv});
        chk("rd_done", {15'h0, rd_done}, {15'h0, cur.rdd});
        chk("rd_data", rd_data, m_rd);
    end

    // panel model: presents the next word on each falling read strobe
    logic [15:0] bus_vals[3];
    int          bus_idx = 0;
    always @(negedge lcd_rd_n or posedge lcd_cs_n) begin
        if (lcd_cs_n) bus_idx = 0;
        else begin
            lcd_data_i = bus_vals[bus_idx];
            bus_idx++;
        end
    end

    int          wok_cnt = 0, wco_cnt = 0, rdv_cnt = 0;
    logic        aaaa_seen = 1'b0, beef_seen = 1'b0;
    logic [15:0] rdq[$];
    always @(negedge clk) begin
        if (write_ok) wok_cnt++;
        if (write_color_ok) wco_cnt++;
        if (rd_valid) begin rdv_cnt++; rdq.push_back(rd_data); end
        if (rd_data == 16'hAAAA) aaaa_seen = 1'b1;
        if (lcd_data_o == 16'hBEEF) beef_seen = 1'b1;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic rs, input logic [15:0] d,
                         input logic idf, input logic rc);
        we = 1'b1; wr = w; lcd_rs_i = rs; data = d; id_fm = idf; read_color = rc;
        step();
        we = 1'b0;
    endtask

    task automatic wait_wok();
        int c;
        c = 0;
        while (!write_ok && c < 100) begin step(); c++; end
        chk("wait_write_ok_timeout", {15'h0, write_ok}, 16'h1);
    endtask

    task automatic wait_rdd(output int c);
        c = 1;
        while (!rd_done && c < 200) begin step(); c++; end
    endtask

    initial begin
        int c, wco0, rdv0, wok0;
        // reset with a stray request present
        we = 1'b1; wr = 1'b1; data = 16'hFFFF;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_wr_n", {15'h0, lcd_wr_n}, 16'h1);
            chk("rst_cs_n", {15'h0, lcd_cs_n}, 16'h1);
        end
        we = 1'b0;
        rst_n = 1'b1;
        step(); step();

        // command write
        issue(1'b1, 1'b0, 16'h002C, 1'b0, 1'b0);
        chk("cmd_wr_n_k1", {15'h0, lcd_wr_n}, 16'h0); step();
        chk("cmd_wr_n_k2", {15'h0, lcd_wr_n}, 16'h0); step();
        chk("cmd_wr_n_k3", {15'h0, lcd_wr_n}, 16'h1); step();
        chk("cmd_wr_n_k4", {15'h0, lcd_wr_n}, 16'h1); step();
        chk("cmd_write_ok_k5", {15'h0, write_ok}, 16'h1);
        chk("cmd_wco_k5", {15'h0, write_color_ok}, 16'h0);
        step(); step();

        // back-to-back data writes
        wco0 = wco_cnt;
        issue(1'b1, 1'b1, 16'hF800, 1'b0, 1'b0);
        wait_wok();
        chk("b2b_gap_cs_n", {15'h0, lcd_cs_n}, 16'h1);
        chk("b2b_gap_busy", {15'h0, busy}, 16'h0);
        issue(1'b1, 1'b1, 16'h07E0, 1'b0, 1'b0);
        chk("b2b_second_cs_n", {15'h0, lcd_cs_n}, 16'h0);
        chk("b2b_second_data", lcd_data_o, 16'h07E0);
        wait_wok();
        chk("b2b_wco_count", 16'(wco_cnt - wco0), 16'd2);
        step(); step();

        // ID read
        bus_vals[0] = 16'h5555; bus_vals[1] = 16'h0093; bus_vals[2] = 16'h0000;
        rdv0 = rdv_cnt;
        issue(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
        wait_rdd(c);
        chk("id_rd_done_cycle", 16'(c), 16'd17);
        chk("id_rd_data", rd_data, 16'h0093);
        chk("id_rd_valid_count", 16'(rdv_cnt - rdv0), 16'd1);
        step(); step();

        // frame-memory colour read
        bus_vals[0] = 16'hAAAA; bus_vals[1] = 16'h1234; bus_vals[2] = 16'h5678;
        rdv0 = rdv_cnt;
        rdq.delete();
        issue(1'b0, 1'b1, 16'h0, 1'b1, 1'b1);
        wait_rdd(c);
        chk("fm_rd_done_cycle", 16'(c), 16'd43);
        chk("fm_rd_valid_count", 16'(rdv_cnt - rdv0), 16'd2);
        chk("fm_first_word", (rdq.size() > 0) ? rdq[0] : 16'hXXXX, 16'h1234);
        chk("fm_second_word", (rdq.size() > 1) ? rdq[1] : 16'hXXXX, 16'h5678);
        chk("fm_no_dummy", {15'h0, aaaa_seen}, 16'h0);
        step(); step();

        // reset during WR_LO
        wok0 = wok_cnt;
        issue(1'b1, 1'b1, 16'h1357, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_n", {15'h0, lcd_wr_n}, 16'h1);
        chk("arst_cs_n", {15'h0, lcd_cs_n}, 16'h1);
        chk("arst_oe", {15'h0, lcd_data_oe}, 16'h0);
        chk("arst_rd_data", rd_data, 16'h0);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) step();
        chk("arst_no_write_ok", 16'(wok_cnt - wok0), 16'd0);

        // request while busy is ignored
        issue(1'b1, 1'b0, 16'h1111, 1'b0, 1'b0);
        issue(1'b1, 1'b1, 16'hBEEF, 1'b0, 1'b0);
        wait_wok();
        for (int i = 0; i < 6; i++) step();
        chk("busy_req_ignored", {15'h0, beef_seen}, 16'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_bus_driver.md
# lcd_bus_driver

Pin-level engine for the 8080-style parallel LCD bus, sitting between the LCD request mux and the panel pads. It accepts one write or read request at a time on the mux-side request port and generates the CS/RS/WR/RD strobes and the 16-bit data bus with parameterised phase timing. It reports completion back to the request side: write-done pulses, read data words and busy. Read sequences insert and discard the controller's mandatory dummy read.

## Interface
- WR_LOW, default 2: cycles lcd_wr_n held low per write (≥1)
- WR_HIGH, default 2: cycles lcd_wr_n held high after the low phase (≥1)
- RD_ID_LOW, default 4: lcd_rd_n low cycles for register/ID reads (≥1)
- RD_FM_LOW, default 10: lcd_rd_n low cycles for frame-memory reads (≥1)
- RD_HIGH, default 4: lcd_rd_n high cycles after each read strobe (≥1)
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- we  in  1  request strobe; accepted only when busy=0
- wr  in  1  1 = write, 0 = read
- lcd_rs_i  in  1  0 = command, 1 = data
- data  in  16  write data
- id_fm  in  1  read timing select: 0 = ID (RD_ID_LOW), 1 = frame memory (RD_FM_LOW)
- read_color  in  1  1 = two data words after the dummy read; 0 = one
- busy  out  1  transaction in progress
- write_ok  out  1  one-cycle pulse: any write finished
- write_color_ok  out  1  one-cycle pulse: data write (rs=1) finished
- rd_valid  out  1  one-cycle pulse: rd_data holds a non-dummy word
- rd_data  out  16  last sampled read word
- rd_done  out  1  one-cycle pulse: read sequence finished
- lcd_cs_n, lcd_wr_n, lcd_rd_n, lcd_rs  out  1 each  panel strobes
- lcd_data_o  out  16  bus drive value
- lcd_data_oe  out  1  bus output enable (1 = drive)
- lcd_data_i  in  16  bus sample value

## Operation
- All outputs are registered.
- Reset values: busy=0, all pulses=0, rd_data=0, lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1, lcd_rs=1, lcd_data_o=0, lcd_data_oe=0.
- States: IDLE, WR_LO, WR_HI, RD_LO, RD_HI. A phase counter is sized $clog2(max param + 1). A strobe counter covers at most 3 strobes.
- Acceptance: in IDLE, we=1 latches wr, lcd_rs_i, data, id_fm and read_color. Requests with we=1 while busy=1 are ignored and produce no side effects.
- Write:
  - IDLE→WR_LO (WR_LOW cycles) →WR_HI (WR_HIGH cycles) →IDLE.
  - lcd_cs_n=0, lcd_rs=latched rs, lcd_data_o=data and lcd_data_oe=1 are held through both phases.
- Read:
  - Strobe count N = 1 + (read_color ? 2 : 1). Strobe 0 is the dummy read.
  - Each strobe is RD_LO (low length from latched id_fm) then RD_HI (RD_HIGH cycles). After RD_HI, the next strobe starts, or the FSM returns to IDLE after strobe N-1.
  - lcd_data_oe=0 and lcd_cs_n=0 throughout the sequence.
- Read sampling: lcd_data_i is sampled into rd_data on the clock edge ending each RD_LO.
  - The dummy sample is discarded: rd_data is not updated and no rd_valid.
  - Non-dummy samples update rd_data and pulse rd_valid in the first RD_HI cycle.
- Completion: on the return to IDLE, the first IDLE cycle shows busy=0, lcd_cs_n=1, lcd_wr_n=1, lcd_rd_n=1, lcd_data_oe=0, plus these pulses in that same cycle:
  - write_ok=1 for any write.
  - write_color_ok=1 additionally for a data write (rs=1).
  - rd_done=1 for a read.
- rd_data holds its value until the next non-dummy sample.
- Asynchronous reset mid-transaction returns the FSM to IDLE and all outputs to reset values immediately. No completion pulse is emitted.

## Timing
- Request accepted at edge k: busy=1, lcd_cs_n=0 and the first strobe low are all visible from cycle k+1.
- Write: busy high for WR_LOW+WR_HIGH cycles; lcd_wr_n rises after WR_LOW cycles; write_ok at cycle k+1+WR_LOW+WR_HIGH.
- Read: busy high for N·(RD_LO len + RD_HIGH) cycles.
- Back-to-back: a request with we=1 in the completion cycle is accepted there.
  - lcd_cs_n is high for exactly one cycle between transactions.
  - busy shows a single low cycle.

## Test plan
- Reset with all inputs idle: every output equals its reset value; drive we=1 during reset: no strobe.
- Command write, data=16'h002C, rs=0, default params: lcd_wr_n low in cycles k+1..k+2 and high in k+3..k+4; write_ok at k+5; write_color_ok stays 0.
- Data write, rs=1, data=16'hF800, then a second write issued in the completion cycle: write_color_ok pulses twice; lcd_cs_n high for exactly one cycle between the writes; data bus 16'hF800 held stable while lcd_wr_n is low.
- ID read (id_fm=0, read_color=0) with lcd_data_i=16'h0093 on the second strobe: two 4-cycle strobes; one rd_valid with rd_data=16'h0093; rd_done at k+17; lcd_data_oe=0 throughout.
- FM read (id_fm=1, read_color=1), bus values 16'hAAAA (dummy), 16'h1234, 16'h5678: three 10-cycle strobes; rd_valid twice (16'h1234, then 16'h5678); rd_data never equals 16'hAAAA.
- Assert rst_n=0 during WR_LO, and separately we=1 while busy: strobes deassert asynchronously with no write_ok; the ignored request never appears on the bus.
